// File: rtl/knap_pkg.sv
// Shared constants for the knapsack search: item table, default sizes, FSM states.
package knap_pkg;

    localparam int NUM_ITEMS_DEF = 7;
    localparam int VW_DEF        = 6;
    localparam int TBL_ITEMS     = 7;

    // Index 0 is item A ... index 6 is item G.
    localparam int unsigned ITEM_VAL [TBL_ITEMS] = '{4, 2, 2, 1, 10, 12, 10};
    localparam int unsigned ITEM_WT  [TBL_ITEMS] = '{12, 1, 2, 1, 4, 2, 2};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/knap_eval.sv
// Combinational candidate evaluator: selection mask -> total value and weight.
module knap_eval
    import knap_pkg::*;
#(
    parameter int NUM_ITEMS = NUM_ITEMS_DEF,
    parameter int SW        = VW_DEF + 1
) (
    input  logic [NUM_ITEMS-1:0] cand,
    output logic [SW-1:0]        value,
    output logic [SW-1:0]        weight
);

    // Sum the table entries of every selected item; SW is wide enough not to wrap.
    always_comb begin
        value  = '0;
        weight = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (cand[i]) begin
                value  = value  + SW'(ITEM_VAL[i]);
                weight = weight + SW'(ITEM_WT[i]);
            end
        end
    end

endmodule

// File: rtl/knap_search.sv
// Exhaustive knapsack search: scans every item subset, one per cycle, through a
// one-stage evaluate/compare pipeline and reports the best subset within limits.
// Optional macro KNAP_COUNT_EN enables the valid-candidate counter; without it
// valid_count is tied to 0.
module knap_search
    import knap_pkg::*;
#(
    parameter int NUM_ITEMS = NUM_ITEMS_DEF,
    parameter int VW        = VW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [VW-1:0]        min_value,
    input  logic [VW-1:0]        max_weight,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic [NUM_ITEMS-1:0] best_sel,
    output logic [VW-1:0]        best_value,
    output logic [NUM_ITEMS:0]   valid_count
);

    localparam int SW = VW + 1;

    state_t state, state_nxt;

    logic [NUM_ITEMS-1:0] cand;
    logic [SW-1:0]        cand_val, cand_wt;
    logic [VW-1:0]        min_lat, max_lat;

    // Pipeline stage between evaluation and compare
    logic                 vld_pipe;
    logic [NUM_ITEMS-1:0] pipe_cand;
    logic [SW-1:0]        pipe_val, pipe_wt;

    logic [SW-1:0]        best_wt;
    logic                 accept, cand_ok, better;

    knap_eval #(.NUM_ITEMS(NUM_ITEMS), .SW(SW)) u_eval (
        .cand   (cand),
        .value  (cand_val),
        .weight (cand_wt)
    );

    assign accept  = (state == S_IDLE) && start;
    assign cand_ok = vld_pipe && (pipe_val >= SW'(min_lat)) && (pipe_wt <= SW'(max_lat));
    // Strict comparisons keep the earliest candidate on a full tie.
    assign better  = !found || (pipe_val > SW'(best_value)) ||
                     ((pipe_val == SW'(best_value)) && (pipe_wt < best_wt));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SCAN;
            S_SCAN: begin
                busy = 1'b1;
                if (cand == '1) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Candidate counter, evaluation pipeline and best-so-far tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand       <= '0;
            min_lat    <= '0;
            max_lat    <= '0;
            vld_pipe   <= 1'b0;
            pipe_cand  <= '0;
            pipe_val   <= '0;
            pipe_wt    <= '0;
            found      <= 1'b0;
            best_sel   <= '0;
            best_value <= '0;
            best_wt    <= '0;
        end else begin
            vld_pipe <= (state == S_SCAN);
            if (state == S_SCAN) begin
                pipe_cand <= cand;
                pipe_val  <= cand_val;
                pipe_wt   <= cand_wt;
                cand      <= cand + NUM_ITEMS'(1);
            end
            if (accept) begin
                min_lat    <= min_value;
                max_lat    <= max_weight;
                cand       <= '0;
                found      <= 1'b0;
                best_sel   <= '0;
                best_value <= '0;
                best_wt    <= '0;
            end else if (cand_ok && better) begin
                found      <= 1'b1;
                best_sel   <= pipe_cand;
                best_value <= pipe_val[VW-1:0];
                best_wt    <= pipe_wt;
            end
        end
    end

`ifdef KNAP_COUNT_EN
    // Count every candidate that meets both limits (at most 2^NUM_ITEMS)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       valid_count <= '0;
        else if (accept)  valid_count <= '0;
        else if (cand_ok) valid_count <= valid_count + (NUM_ITEMS+1)'(1);
    end
`else
    assign valid_count = '0;
`endif

endmodule

// File: tb/tb_knap_search.sv
// Scoreboard bench for knap_search: stimulus pushes model results, monitor checks on done.
module tb_knap_search;

    localparam int N  = 7;
    localparam int VW = 6;
    localparam int LAT = (1 << N) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [VW-1:0] min_value, max_weight;
    logic          busy, done, found;
    logic [N-1:0]  best_sel;
    logic [VW-1:0] best_value;
    logic [N:0]    valid_count;

    knap_search #(.NUM_ITEMS(N), .VW(VW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .min_value(min_value), .max_weight(max_weight),
        .busy(busy), .done(done), .found(found),
        .best_sel(best_sel), .best_value(best_value), .valid_count(valid_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int f;
        int sel;
        int val;
        int cnt;
        int n;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   cyc = 0;

    int tv [7] = '{4, 2, 2, 1, 10, 12, 10};
    int tw [7] = '{12, 1, 2, 1, 4, 2, 2};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        total_cnt++;
        if (act == exp_v) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    endtask

    function automatic int sv(input int c);
        int s = 0;
        for (int i = 0; i < N; i++) if (c[i]) s += tv[i];
        return s;
    endfunction

    function automatic int sw(input int c);
        int s = 0;
        for (int i = 0; i < N; i++) if (c[i]) s += tw[i];
        return s;
    endfunction

    // Reference: highest value, then lowest weight, then lowest index among valid subsets.
    function automatic exp_t model(input int mn, input int mx, input int n_acc);
        exp_t e;
        int top_v = -1, top_w = 1000, cnt = 0, pick = 0;
        for (int c = 0; c < (1 << N); c++)
            if (sv(c) >= mn && sw(c) <= mx) begin
                cnt++;
                if (sv(c) > top_v) top_v = sv(c);
            end
        for (int c = 0; c < (1 << N); c++)
            if (sv(c) == top_v && sw(c) <= mx && sw(c) < top_w) top_w = sw(c);
        for (int c = (1 << N) - 1; c >= 0; c--)
            if (sv(c) == top_v && sw(c) == top_w) pick = c;
        e.f   = (cnt > 0) ? 1 : 0;
        e.sel = (cnt > 0) ? pick : 0;
        e.val = (cnt > 0) ? top_v : 0;
`ifdef KNAP_COUNT_EN
        e.cnt = cnt;
`else
        e.cnt = 0;
`endif
        e.n   = n_acc;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_latency", cyc, e.n + LAT);
                chk("found", int'(found), e.f);
                chk("best_sel", int'(best_sel), e.sel);
                chk("best_value", int'(best_value), e.val);
                chk("valid_count", int'(valid_count), e.cnt);
            end
        end
    end

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            chk({name, "_timeout"}, sb.size(), 0);
            sb.delete();
        end
    endtask

    // Issue a search; thresholds are scrambled once accepted to show they are latched.
    task automatic launch(input int mn, input int mx);
        @(negedge clk);
        start = 1'b1;
        min_value = VW'(mn);
        max_weight = VW'(mx);
        @(posedge clk);
        #1;
        sb.push_back(model(mn, mx, cyc));
        chk("busy_after_start", int'(busy), 1);
        start = 1'b0;
        min_value = VW'($urandom);
        max_weight = VW'($urandom);
    endtask

    task automatic run_search(input string name, input int mn, input int mx);
        launch(mn, mx);
        wait_drain(name);
    endtask

    initial begin
        start = 1'b0;
        min_value = '0;
        max_weight = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_found", int'(found), 0);
        chk("rst_best_sel", int'(best_sel), 0);
        chk("rst_best_value", int'(best_value), 0);
        chk("rst_valid_count", int'(valid_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed boundary cases
        run_search("s15_16", 15, 16);
        run_search("s0_0", 0, 0);
        run_search("s63_63", 63, 63);
        run_search("s0_63", 0, 63);

        // Start pulses and threshold changes while busy are ignored
        launch(20, 10);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            min_value = VW'($urandom);
            max_weight = VW'($urandom);
            @(negedge clk);
            start = 1'b0;
            repeat (7) @(negedge clk);
        end
        wait_drain("busy_start");

        // Reset at cycle 40 of SCAN aborts with no done pulse
        launch(10, 20);
        repeat (39) @(posedge clk);
        @(negedge clk);
        sb.delete();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_found", int'(found), 0);
        chk("abort_best_sel", int'(best_sel), 0);
        chk("abort_best_value", int'(best_value), 0);
        chk("abort_valid_count", int'(valid_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        run_search("after_abort", 10, 20);

        // Back-to-back: start held through DONE, re-accepted in the next IDLE cycle
        @(negedge clk);
        start = 1'b1;
        min_value = VW'(25);
        max_weight = VW'(9);
        @(posedge clk);
        #1;
        sb.push_back(model(25, 9, cyc));
        sb.push_back(model(25, 9, cyc + LAT + 2));
        for (int i = 0; i < 400 && sb.size() > 1; i++) @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("b2b_busy", int'(busy), 1);
        start = 1'b0;
        wait_drain("b2b");

        // Randomized searches
        for (int k = 0; k < 8; k++)
            run_search("rand", int'($urandom_range(0, 41)), int'($urandom_range(0, 30)));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/knap_search.md
KNAP_SEARCH -- requirements
Module: knap_search

Interface
REQ-001 Parameter NUM_ITEMS, default 7, number of selectable items; candidate width.
REQ-002 Parameter VW, default 6, width of value/weight thresholds and result value.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request a search; sampled only in IDLE.
REQ-007 min_value  input  VW  minimum total value; latched when start is accepted.
REQ-008 max_weight  input  VW  maximum total weight; latched when start is accepted.
REQ-009 busy  output  1  high in SCAN and FLUSH.
REQ-010 done  output  1  one-cycle pulse when a search completes.
REQ-011 found  output  1  at least one candidate met both limits.
REQ-012 best_sel  output  NUM_ITEMS  best candidate; bit0=item A ... bit6=item G.
REQ-013 best_value  output  VW  total value of best_sel.
REQ-014 valid_count  output  NUM_ITEMS+1  number of candidates meeting both limits.

Function
REQ-015 FSM states: IDLE, SCAN, FLUSH, DONE.
REQ-016 IDLE -> SCAN on start=1: latch thresholds, cand=0, clear found/best_sel/best_value/valid_count.
REQ-017 SCAN: one candidate per cycle; cand increments 0..2^NUM_ITEMS-1, and the state moves to FLUSH after the last candidate.
REQ-018 Evaluation pipeline: cycle k forms value/weight sums of cand combinationally and registers them with cand; the compare/update happens in cycle k+1.
REQ-019 Item table (value/weight): A 4/12, B 2/1, C 2/2, D 1/1, E 10/4, F 12/2, G 10/2.
REQ-020 Sums are carried at VW+1 bits internally, with no wrap; max sums are 41 and 24.
REQ-021 A candidate is valid iff value >= min_value and weight <= max_weight, both unsigned.
REQ-022 A valid candidate replaces the best if: found=0, or value > best_value, or value == best_value with strictly lower weight.
REQ-023 On remaining ties the earliest (lowest) candidate wins.
REQ-024 FLUSH: one cycle for the last pipelined compare, then DONE.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE.
REQ-026 Latency: with start accepted at edge N, done is high in the cycle after edge N+2^NUM_ITEMS+1 (N+129 at default).
REQ-027 Results hold stable from done until the next accepted start.
REQ-028 start in SCAN/FLUSH/DONE is ignored, and threshold changes while busy have no effect.
REQ-029 Back-to-back: start held high through DONE is accepted in the following IDLE cycle.

Reset
REQ-030 rst_n low: state=IDLE, cand=0, pipeline regs 0, busy=0, done=0, found=0, best_sel=0, best_value=0, valid_count=0.
REQ-031 Reset mid-search aborts immediately and does not produce a done pulse.

Configuration
REQ-032 Macro KNAP_COUNT_EN defined: valid_count increments once per valid candidate (max 128, no overflow).
REQ-033 Macro KNAP_COUNT_EN undefined: the counter logic is absent, and valid_count is constant 0.

Structure
REQ-034 Shared package knap_pkg holds the item value/weight constant arrays, NUM_ITEMS default, and the FSM state enum.
REQ-035 One sub-module knap_eval: combinational cand -> value sum, weight sum, using knap_pkg constants.

Verification
REQ-036 Scenario: min_value=15, max_weight=16, start -> done at N+129; found=1, best_sel=7'h7E, best_value=37.
REQ-037 Scenario: min_value=0, max_weight=0 -> found=1, best_sel=0, best_value=0, valid_count=1 (KNAP_COUNT_EN).
REQ-038 Scenario: min_value=63, max_weight=63 -> found=0, best_sel=0, best_value=0, valid_count=0.
REQ-039 Scenario: min_value=0, max_weight=63 -> best_sel=7'h7F, best_value=41, valid_count=128.
REQ-040 Scenario: rst_n low at cycle 40 of SCAN -> all outputs 0 and no done pulse; a new start gives a full correct result.
REQ-041 Scenario: start pulsed again while busy and thresholds toggled -> no restart; results match the first thresholds.
